sprite_color_mapper: RTL
========================

Name: sprite_color_mapper

Overview:
- Pipelined, parametrised colour mapper for the VGA path. Draws up to N_OBJ axis-aligned rectangles (object 0 is the player; the rest are platforms) over a state-dependent background.
- Object registers are double-buffered and swap at frame start, so an object cannot tear mid-frame.
- Adds fixed-priority overlap resolution, per-object colour, and a frame-counted blink of object 0 on game over.
- Sits between the game logic (positions, outstate) and the VGA controller (DrawX/DrawY in, RGB out).

Parameters:
- N_OBJ, 4, number of rectangles; index 0 has the highest priority.
- COORD_W, 10, coordinate and half-size width.
- BLINK_FRAMES, 8, frames per blink phase; the blink period is 2*BLINK_FRAMES.
- BG_PLAY, 24'h000000, background RGB in play.
- BG_MENU, 24'h202080, background RGB in menu.
- BG_OVER, 24'h400000, background RGB in game over.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- pixel_en  in  1  pixel-rate enable; the pipeline advances only when this is 1.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- DrawX  in  COORD_W  current pixel column.
- DrawY  in  COORD_W  current pixel row.
- obj_x  in  N_OBJ*COORD_W  centre X per object; object i occupies bits [i*COORD_W +: COORD_W].
- obj_y  in  N_OBJ*COORD_W  centre Y per object, same packing.
- obj_size  in  N_OBJ*COORD_W  half-extent per object (square), same packing.
- obj_color  in  N_OBJ*24  RGB per object, {R,G,B}.
- obj_en  in  N_OBJ  object visible.
- outstate  in  3  game state: 0 = menu, 1 = play, 2 = game over, 3..7 = treated as play.
- Red  out  8  red component.
- Green  out  8  green component.
- Blue  out  8  blue component.
- hit_valid  out  1  some object owns the output pixel.
- hit_id  out  $clog2(N_OBJ)  index of the owning object.

Behaviour:
- Reset (asynchronous, Reset=0): Red/Green/Blue=0, hit_valid=0, hit_id=0. Shadow obj_* registers and obj_en cleared. Frame counter=0. Pipeline valid bits=0.
- Shadow load: on a Clk edge with frame_start=1, every obj_x/y/size/color/en and outstate is captured into the shadow registers.
  - All drawing uses shadow values only. Inputs may change freely mid-frame.
  - If frame_start and pixel_en are both 1 on the same edge, stage 1 on that edge uses the old shadow values.
- Frame counter: increments on each frame_start and wraps from 2*BLINK_FRAMES-1 to 0. blink_off = (counter >= BLINK_FRAMES).
- Stage 1 (on an edge with pixel_en=1): for each i, in_box[i] is registered as 1 when all of the following hold:
  - shadow en[i]
  - DrawX >= lo_x and DrawX <= hi_x
  - DrawY >= lo_y and DrawY <= hi_y
- Bounds arithmetic (bounds inclusive):
  - lo = centre - size, clamped to 0 on underflow.
  - hi = centre + size, saturated at 2^COORD_W-1 on overflow.
  - Compute in COORD_W+1 bits; there is no wrap-around.
- Masking:
  - outstate_shadow=0 (menu): all in_box are forced to 0.
  - outstate_shadow=2 and blink_off=1: in_box[0] is forced to 0.
- Stage 2 (on an edge with pixel_en=1):
  - Priority-encode in_box, lowest index wins.
  - hit_valid = OR of in_box; hit_id = the winner (0 when there is no hit).
  - RGB = winner colour, otherwise the background selected by outstate_shadow.
- Latency: RGB for the DrawX/DrawY sampled at pixel_en edge k appears after pixel_en edge k+1, i.e. 2 enabled edges.
  - With pixel_en=0 all pipeline and output registers hold.
- Reset asserted mid-frame: outputs go to 0 immediately. After release, nothing is drawn until the next frame_start loads the shadows; the background is BG_MENU during that time because outstate_shadow resets to 0.

Test Plan:
- Reset, pixel_en=1, no frame_start -> RGB=BG_MENU, hit_valid=0 for every pixel.
- Object 0 at (320,240), size 4, colour 00FF00, en=1, outstate=1, then frame_start; sweep DrawX 315..325 at DrawY 240:
  - RGB=00FF00 and hit_id=0 for X 316..324.
  - RGB=000000 at X 315 and X 325.
  - Each result appears 2 enabled edges after its DrawX.
- Objects 0 and 2 overlap at (100,100), object 2 colour FF0000 -> pixel (100,100) gives hit_id=0 with object 0's colour. With obj_en[0]=0 loaded at the next frame_start -> hit_id=2, RGB=FF0000.
- Object 1 at x=2, size 5 (underflow) and at x=1020, size 10 (overflow):
  - Underflow case: pixel X=0 is drawn.
  - Overflow case: pixel X=1023 is drawn and X=1009 is not.
  - No wrap artefacts at X=1000.
- Change obj_x mid-frame without frame_start -> output unchanged until the next frame_start pulse.
- outstate=2, BLINK_FRAMES=8, 32 frame_start pulses:
  - Object 0 is visible in frames 0-7 and 16-23 and hidden in frames 8-15 and 24-31.
  - Background stays BG_OVER throughout; other objects are unaffected.
  - With pixel_en toggled at 1/2 rate, outputs hold between enabled edges.

Source files
------------

// File: rtl/sprite_color_mapper.sv
// Two-stage colour mapper: rectangle hit test against frame-latched object
// registers, then fixed-priority resolution to RGB over a state background.
module sprite_color_mapper #(
    parameter int          N_OBJ        = 4,
    parameter int          COORD_W      = 10,
    parameter int          BLINK_FRAMES = 8,
    parameter logic [23:0] BG_PLAY      = 24'h000000,
    parameter logic [23:0] BG_MENU      = 24'h202080,
    parameter logic [23:0] BG_OVER      = 24'h400000
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       pixel_en,
    input  logic                       frame_start,
    input  logic [COORD_W-1:0]         DrawX,
    input  logic [COORD_W-1:0]         DrawY,
    input  logic [N_OBJ*COORD_W-1:0]   obj_x,
    input  logic [N_OBJ*COORD_W-1:0]   obj_y,
    input  logic [N_OBJ*COORD_W-1:0]   obj_size,
    input  logic [N_OBJ*24-1:0]        obj_color,
    input  logic [N_OBJ-1:0]           obj_en,
    input  logic [2:0]                 outstate,
    output logic [7:0]                 Red,
    output logic [7:0]                 Green,
    output logic [7:0]                 Blue,
    output logic                       hit_valid,
    output logic [$clog2(N_OBJ)-1:0]   hit_id
);

    localparam int ID_W  = $clog2(N_OBJ);
    localparam int CNT_W = $clog2(2 * BLINK_FRAMES);

    logic [N_OBJ*COORD_W-1:0] sh_x, sh_y, sh_size;
    logic [N_OBJ*24-1:0]      sh_color;
    logic [N_OBJ-1:0]         sh_en;
    logic [2:0]               sh_state;
    logic [CNT_W-1:0]         frame_cnt;
    logic                     blink_off;

    // Shadow registers swap only at frame start so objects never tear mid-frame.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sh_x      <= '0;
            sh_y      <= '0;
            sh_size   <= '0;
            sh_color  <= '0;
            sh_en     <= '0;
            sh_state  <= '0;
            frame_cnt <= '0;
        end else if (frame_start) begin
            sh_x     <= obj_x;
            sh_y     <= obj_y;
            sh_size  <= obj_size;
            sh_color <= obj_color;
            sh_en    <= obj_en;
            sh_state <= outstate;
            if (frame_cnt == CNT_W'(2 * BLINK_FRAMES - 1))
                frame_cnt <= '0;
            else
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign blink_off = (frame_cnt >= CNT_W'(BLINK_FRAMES));

    function automatic logic [COORD_W-1:0] lo_bound(input logic [COORD_W-1:0] c,
                                                    input logic [COORD_W-1:0] s);
        logic [COORD_W:0] d;
        d = {1'b0, c} - {1'b0, s};
        return d[COORD_W] ? '0 : d[COORD_W-1:0];
    endfunction

    function automatic logic [COORD_W-1:0] hi_bound(input logic [COORD_W-1:0] c,
                                                    input logic [COORD_W-1:0] s);
        logic [COORD_W:0] d;
        d = {1'b0, c} + {1'b0, s};
        return d[COORD_W] ? '1 : d[COORD_W-1:0];
    endfunction

    logic [N_OBJ-1:0] in_box_d;

    always_comb begin
        in_box_d = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            in_box_d[i] = sh_en[i]
                && (DrawX >= lo_bound(sh_x[i*COORD_W +: COORD_W], sh_size[i*COORD_W +: COORD_W]))
                && (DrawX <= hi_bound(sh_x[i*COORD_W +: COORD_W], sh_size[i*COORD_W +: COORD_W]))
                && (DrawY >= lo_bound(sh_y[i*COORD_W +: COORD_W], sh_size[i*COORD_W +: COORD_W]))
                && (DrawY <= hi_bound(sh_y[i*COORD_W +: COORD_W], sh_size[i*COORD_W +: COORD_W]));
        end
        if (sh_state == 3'd0)
            in_box_d = '0;
        else if (sh_state == 3'd2 && blink_off)
            in_box_d[0] = 1'b0;
    end

    // pixel_en is a plain advance enable: every register in the pipe holds while it is low.
    logic             s1_valid;
    logic [N_OBJ-1:0] s1_box;
    logic [2:0]       s1_state;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_valid <= 1'b0;
            s1_box   <= '0;
            s1_state <= '0;
        end else if (pixel_en) begin
            s1_valid <= 1'b1;
            s1_box   <= in_box_d;
            s1_state <= sh_state;
        end
    end

    logic            hit_n;
    logic [ID_W-1:0] id_n;
    logic [23:0]     rgb_n;

    always_comb begin
        hit_n = |s1_box;
        id_n  = '0;
        case (s1_state)
            3'd0:    rgb_n = BG_MENU;
            3'd2:    rgb_n = BG_OVER;
            default: rgb_n = BG_PLAY;
        endcase
        // Scan downwards so the lowest set index is the last assignment and wins.
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (s1_box[i]) begin
                id_n  = ID_W'(i);
                rgb_n = sh_color[i*24 +: 24];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
            hit_valid <= 1'b0;
            hit_id    <= '0;
        end else if (pixel_en) begin
            if (s1_valid) begin
                {Red, Green, Blue} <= rgb_n;
                hit_valid          <= hit_n;
                hit_id             <= id_n;
            end else begin
                {Red, Green, Blue} <= '0;
                hit_valid          <= 1'b0;
                hit_id             <= '0;
            end
        end
    end

endmodule
